// File: rtl/mem_cmd_executor.sv
// Memory-side command engine: pops read/write commands, executes them on an internal register file
// and pushes one response per read. Optional MEM_CLEAR_EN zeroes the memory after every reset.
module mem_cmd_executor #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   cmd_fifo_rd_en,
    input  logic [ADDR_W+DATA_W:0] cmd_fifo_data,
    input  logic                   cmd_fifo_empty,
    output logic                   resp_fifo_wr_en,
    output logic [DATA_W-1:0]      resp_fifo_data,
    input  logic                   resp_fifo_full,
    output logic                   busy,
    output logic [15:0]            wr_count,
    output logic [15:0]            rd_count,
    output logic [ADDR_W-1:0]      last_addr
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_CLEAR  = 3'd0,
        S_IDLE   = 3'd1,
        S_FETCH  = 3'd2,
        S_DECODE = 3'd3,
        S_RESP   = 3'd4
    } state_t;

`ifdef MEM_CLEAR_EN
    localparam state_t RESET_STATE = S_CLEAR;
    localparam logic   RESET_BUSY  = 1'b1;
`else
    localparam state_t RESET_STATE = S_IDLE;
    localparam logic   RESET_BUSY  = 1'b0;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state, state_nx;
    logic [DATA_W-1:0] rd_q, rd_q_nx;
    logic              rd_en_nx, wr_en_nx, busy_nx;
    logic [DATA_W-1:0] resp_data_nx;
    logic [15:0]       wr_count_nx, rd_count_nx;
    logic [ADDR_W-1:0] last_addr_nx;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    assign cmd_op    = cmd_fifo_data[ADDR_W+DATA_W];
    assign cmd_addr  = cmd_fifo_data[ADDR_W+DATA_W-1:DATA_W];
    assign cmd_wdata = cmd_fifo_data[DATA_W-1:0];

`ifdef MEM_CLEAR_EN
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    logic [ADDR_W-1:0] clr_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            clr_addr <= '0;
        else if (state == S_CLEAR)
            clr_addr <= clr_addr + ADDR_ONE;
    end
`endif

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nx     = state;
        rd_en_nx     = 1'b0;
        wr_en_nx     = 1'b0;
        resp_data_nx = resp_fifo_data;
        rd_q_nx      = rd_q;
        wr_count_nx  = wr_count;
        rd_count_nx  = rd_count;
        last_addr_nx = last_addr;
        mem_we       = 1'b0;
        mem_waddr    = cmd_addr;
        mem_wdata    = cmd_wdata;

        case (state)
`ifdef MEM_CLEAR_EN
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr;
                mem_wdata = '0;
                if (clr_addr == '1)
                    state_nx = S_IDLE;
            end
`endif
            S_IDLE: begin
                if (!cmd_fifo_empty) begin
                    rd_en_nx = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            // The popped word appears on cmd_fifo_data only in the following cycle.
            S_FETCH: state_nx = S_DECODE;
            S_DECODE: begin
                last_addr_nx = cmd_addr;
                if (cmd_op) begin
                    mem_we      = 1'b1;
                    wr_count_nx = wr_count + 16'd1;
                    state_nx    = S_IDLE;
                end else begin
                    rd_q_nx  = mem[cmd_addr];
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                if (!resp_fifo_full) begin
                    wr_en_nx     = 1'b1;
                    resp_data_nx = rd_q;
                    rd_count_nx  = rd_count + 16'd1;
                    state_nx     = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        busy_nx = (state_nx != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RESET_STATE;
            rd_q            <= '0;
            cmd_fifo_rd_en  <= 1'b0;
            resp_fifo_wr_en <= 1'b0;
            resp_fifo_data  <= '0;
            busy            <= RESET_BUSY;
            wr_count        <= '0;
            rd_count        <= '0;
            last_addr       <= '0;
        end else begin
            state           <= state_nx;
            rd_q            <= rd_q_nx;
            cmd_fifo_rd_en  <= rd_en_nx;
            resp_fifo_wr_en <= wr_en_nx;
            resp_fifo_data  <= resp_data_nx;
            busy            <= busy_nx;
            wr_count        <= wr_count_nx;
            rd_count        <= rd_count_nx;
            last_addr       <= last_addr_nx;
        end
    end

    // NOTE: the memory array has no reset; only the optional clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

endmodule
